// File: rtl/sccb_responder_if.sv
// Register-side port of the SCCB responder: write strobe toward a register file
// plus the registered sub-address and the read data returned for it.
interface sccb_responder_if;
    // wr_en is a one-clk valid with no back-pressure: wr_addr/wr_data are stable
    // while it is high. rd_data must follow rd_addr within 2 clk.
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       txn_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, busy, txn_done,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, busy, txn_done,
        output rd_data
    );
endinterface

// File: rtl/sccb_responder.sv
// SCCB responder: oversamples SCL/SDA, decodes START/STOP, ACKs its device ID,
// turns write bytes into register writes and serves reads from rd_data.
module sccb_responder #(
    parameter logic [6:0] DEV_ID = 7'h21
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl,
    inout  wire              sda,
    sccb_responder_if.master rif,
    output logic [3:0]       dbg_state
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ID       = 4'd1,
        ID_ACK   = 4'd2,
        ADDR     = 4'd3,
        ADDR_ACK = 4'd4,
        DATA     = 4'd5,
        DATA_ACK = 4'd6,
        RD_BYTE  = 4'd7,
        RD_ACK   = 4'd8,
        IGNORE   = 4'd9
    } state_t;

    logic scl_s1, scl_s2, scl_q;
    logic sda_s1, sda_s2, sda_q;
    logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;

    state_t     state, state_n;
    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] rx_sh, rx_sh_n, tx_sh, tx_sh_n, rx_byte;
    logic [7:0] rd_addr, rd_addr_n, wr_addr, wr_addr_n, wr_data, wr_data_n;
    logic       sda_low, sda_low_n, wr_en, wr_en_n, busy, busy_n;
    logic       txn_done, txn_done_n, id_match, id_match_n, rw, rw_n;

    // Sync flops reset to the idle-bus level so reset release creates no edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {scl_s1, scl_s2, scl_q} <= 3'b111;
            {sda_s1, sda_s2, sda_q} <= 3'b111;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_q  <= scl_s2;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
            sda_q  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_q;
    assign scl_fall  = ~scl_s2 & scl_q;
    assign sda_rise  = sda_s2 & ~sda_q;
    assign sda_fall  = ~sda_s2 & sda_q;
    // SCL must be stable high on both samples; a simultaneous change is a data event.
    assign start_det = sda_fall & scl_s2 & scl_q;
    assign stop_det  = sda_rise & scl_s2 & scl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            rx_sh    <= 8'd0;
            tx_sh    <= 8'd0;
            rd_addr  <= 8'd0;
            wr_addr  <= 8'd0;
            wr_data  <= 8'd0;
            sda_low  <= 1'b0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            txn_done <= 1'b0;
            id_match <= 1'b0;
            rw       <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            rx_sh    <= rx_sh_n;
            tx_sh    <= tx_sh_n;
            rd_addr  <= rd_addr_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            sda_low  <= sda_low_n;
            wr_en    <= wr_en_n;
            busy     <= busy_n;
            txn_done <= txn_done_n;
            id_match <= id_match_n;
            rw       <= rw_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        rx_sh_n    = rx_sh;
        tx_sh_n    = tx_sh;
        rd_addr_n  = rd_addr;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        sda_low_n  = sda_low;
        wr_en_n    = 1'b0;
        busy_n     = busy;
        txn_done_n = 1'b0;
        id_match_n = id_match;
        rw_n       = rw;
        rx_byte    = {rx_sh[6:0], sda_s2};

        if (start_det) begin
            state_n    = ID;
            bit_cnt_n  = 4'd0;
            sda_low_n  = 1'b0;
            busy_n     = 1'b1;
            id_match_n = 1'b0;
        end else if (stop_det) begin
            state_n    = IDLE;
            bit_cnt_n  = 4'd0;
            sda_low_n  = 1'b0;
            busy_n     = 1'b0;
            txn_done_n = id_match;
        end else begin
            case (state)
                ID, ADDR, DATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        rx_sh_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7 && state == ADDR) rd_addr_n = rx_byte;
                        if (bit_cnt == 4'd7 && state == DATA) begin
                            wr_en_n   = 1'b1;
                            wr_addr_n = rd_addr;
                            wr_data_n = rx_byte;
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_n = 4'd0;
                        if (state == ID && rx_sh[7:1] != DEV_ID) begin
                            state_n = IGNORE;
                        end else begin
                            sda_low_n = 1'b1;
                            if (state == ID) begin
                                id_match_n = 1'b1;
                                rw_n       = rx_sh[0];
                                state_n    = ID_ACK;
                            end else if (state == ADDR) begin
                                state_n = ADDR_ACK;
                            end else begin
                                state_n = DATA_ACK;
                            end
                        end
                    end
                end
                ID_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            state_n   = RD_BYTE;
                            tx_sh_n   = rif.rd_data;
                            sda_low_n = ~rif.rd_data[7];
                            bit_cnt_n = 4'd0;
                        end else begin
                            state_n   = ADDR;
                            sda_low_n = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_low_n = 1'b0;
                        state_n   = DATA;
                    end
                end
                DATA_ACK: begin
                    if (scl_fall) begin
                        sda_low_n = 1'b0;
                        rd_addr_n = rd_addr + 8'd1;
                        state_n   = DATA;
                    end
                end
                // bit_cnt counts falls after bit 7 went out; the 8th fall frees SDA.
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd7) begin
                            sda_low_n = 1'b0;
                            bit_cnt_n = 4'd0;
                            state_n   = RD_ACK;
                        end else begin
                            tx_sh_n   = {tx_sh[6:0], 1'b0};
                            sda_low_n = ~tx_sh[6];
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                // bit_cnt=1 marks a master ACK seen on the 9th rise.
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s2) begin
                            state_n = IGNORE;
                        end else begin
                            rd_addr_n = rd_addr + 8'd1;
                            bit_cnt_n = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        state_n   = RD_BYTE;
                        tx_sh_n   = rif.rd_data;
                        sda_low_n = ~rif.rd_data[7];
                        bit_cnt_n = 4'd0;
                    end
                end
                IDLE, IGNORE: ;
                default: state_n = IDLE;
            endcase
        end
    end

    assign sda          = sda_low ? 1'b0 : 1'bz;
    assign rif.wr_en    = wr_en;
    assign rif.wr_addr  = wr_addr;
    assign rif.wr_data  = wr_data;
    assign rif.rd_addr  = rd_addr;
    assign rif.busy     = busy;
    assign rif.txn_done = txn_done;
    assign dbg_state    = state;
endmodule

// File: doc/sccb_responder.md
# sccb_responder

SCCB/I2C-style responder (slave) answering the 3-phase write and 2-phase read transactions issued by our SCCB master. It oversamples SCL/SDA on the system clock, detects START/STOP, matches the device ID, ACKs by pulling SDA low, and presents received register writes on a simple write port. It also serves reads from an external register file. It is used as the camera-side model in system simulation and as an on-chip configuration target.

## Interface
- DEV_ID, 7'h21: 7-bit device address. Write ID byte is 0x42; read ID byte is 0x43.
- clk  in  1  system clock; SCL must be high and low for at least 4 clk each.
- reset  in  1  asynchronous, active-high.
- scl  in  1  bus clock from the master, asynchronous to clk.
- sda  inout  1  open-drain: driven 1'b0 or released to 1'bz; never driven 1.
- wr_en  out  1  one-clk pulse per received data byte.
- wr_addr  out  8  register address for wr_en.
- wr_data  out  8  data for wr_en.
- rd_addr  out  8  current sub-address, registered.
- rd_data  in  8  register contents at rd_addr; must be valid within 2 clk of any rd_addr change.
- busy  out  1  high from a detected START until the next STOP.
- txn_done  out  1  one-clk pulse on STOP ending a transaction whose ID matched.

## Operation
- SCL and SDA input path:
  - Each line passes through a 2-FF synchronizer, then a registered copy (scl_q, sda_q) for edge detection.
  - rise/fall are derived from the synchronized value vs. the _q copy.
- START: SDA fall while SCL is high in both current and previous sample.
- STOP: SDA rise under the same condition.
- If SCL and SDA change in the same sample, it is a data/clock event, not START/STOP.
- Bits are sampled on SCL rise, MSB first.
- States:
  - IDLE: wait for START.
  - ID: receive 8 bits.
  - ID_ACK.
  - ADDR: receive 8 bits.
  - ADDR_ACK.
  - DATA: receive 8 bits.
  - DATA_ACK.
  - RD_BYTE: transmit 8 bits.
  - RD_ACK: sample the master's ACK.
  - IGNORE: wait for STOP.
- START in any state (including a repeated START) clears the bit counter and goes to ID.
- STOP in any state goes to IDLE, releases SDA and clears busy.
- ID byte received:
  - Upper 7 bits ≠ DEV_ID: no ACK, go to IGNORE.
  - Match with R/W=0: ADDR path.
  - Match with R/W=1: read path.
- ACK:
  - On the SCL fall after the 8th bit, drive SDA low.
  - Hold low through the 9th SCL rise.
  - Release on the 9th SCL fall.
- ADDR byte: loaded into rd_addr (the sub-address) when the 8th bit is sampled.
- DATA byte:
  - wr_en pulses 1 clk after the 8th bit is sampled, with wr_addr = rd_addr and wr_data = byte.
  - rd_addr increments at the 9th SCL fall (8-bit wrap, 0xFF→0x00).
  - Then return to DATA for further bytes.
- Read path:
  - At the 9th SCL fall of ID_ACK, load a shifter from rd_data and drive bit 7 (low for 0, release for 1).
  - Shift on each subsequent SCL fall.
  - Release SDA at the 8th fall.
  - In RD_ACK, sample SDA at the 9th rise.
  - Sampled 0 (ACK): increment rd_addr, and at the 9th fall load the next byte and go to RD_BYTE.
  - Sampled 1 (NACK): go to IGNORE.
- txn_done pulses on STOP only if the ID matched since the last START.

## Timing
- Reset values:
  - sda released (z); wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, txn_done=0.
  - State IDLE, counters 0.
- Reset mid-transaction releases SDA asynchronously, the same cycle.
- Latency from bus pin edge to internal event: 3 clk (2 sync + 1 edge register).
- SDA drive changes occur 1 clk after the detected SCL fall, i.e. ≤4 clk after the pin edge. This is well inside the master's ≥250-clk low phase.
- busy rises 1 clk after START is detected and falls 1 clk after STOP is detected.
- wr_en and txn_done are exactly 1 clk wide.

## Test plan
- Write: START, 0x42, 0x12, 0x80, STOP.
  - SDA low during all three 9th clocks.
  - wr_en once with wr_addr=0x12, wr_data=0x80.
  - txn_done once; busy high across the whole transaction.
- ID mismatch: START, 0x60, 0x12, 0x80, STOP.
  - SDA never driven; no wr_en; no txn_done; state IGNORE until STOP.
- Read: write phase 0x42, 0x0A, STOP.
  - Then START, 0x43 with rd_data=0x76, master NACK, STOP.
  - Bits 0,1,1,1,0,1,1,0 observed on SCL rises.
  - SDA released before the 9th clock; rd_addr=0x0A.
- Burst write: 0x42, 0xFF, 0x11, 0x22.
  - wr_en at addr 0xFF data 0x11, then addr 0x00 data 0x22.
- Repeated START after ADDR byte 0x3A, then 0x43:
  - Read serves rd_addr=0x3A with no intervening wr_en.
- Corner cases:
  - Assert reset while the responder is ACKing: SDA is z in the same cycle and all outputs return to reset values.
  - Master STOP1 pattern (SDA 1→0 while SCL 0→1 in the same sample): must not be detected as START.
